// File: rtl/reg_file_initiator.sv
// reg_file_initiator: single-command ALU initiator for the 32x8 register file.
// Accepts one command (ADD/SUB/AND/LDI), reads both operands, computes an 8-bit result and writes it back.
// Latency from accept to done: ALU ops 6 cycles, LDI 3 cycles (4 for ALU ops hitting the last-write bypass).
// Backpressure: cmd_ready is high only while idle; a register file stall longer than TIMEOUT cycles aborts the command.
// Optional feature macro: LAST_WRITE_BYPASS_EN (reuse the last written value instead of reading it back).
// Ports: clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_rs/cmd_rt/cmd_rd/cmd_imm command side;
//        read1/read2/write/write_data/input_valid and out1/out2/output_valid register-file side;
//        done/result/error completion status.
module reg_file_initiator #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_rs,
  input  logic [4:0] cmd_rt,
  input  logic [4:0] cmd_rd,
  input  logic [7:0] cmd_imm,
  output logic [4:0] read1,
  output logic [4:0] read2,
  output logic [4:0] write,
  output logic [7:0] write_data,
  output logic [2:0] input_valid,
  input  logic [7:0] out1,
  input  logic [7:0] out2,
  input  logic       output_valid,
  output logic       done,
  output logic [7:0] result,
  output logic       error
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b11;
  // Last wait cycle: the edge that would bring the counter to TIMEOUT aborts instead.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, EXEC, WR_ISSUE, WR_WAIT, DONE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       op_q, op_nx;
  logic [4:0]       rd_q, rd_nx;
  logic [7:0]       a_q, a_nx, b_q, b_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       read1_nx, read2_nx, write_nx;
  logic [7:0]       wd_nx, result_nx, alu;
  logic [2:0]       iv_nx;
  logic             done_nx, error_nx;
  logic             bypass_hit;
  logic [7:0]       bypass_data;

  assign cmd_ready = (state == IDLE);

`ifdef LAST_WRITE_BYPASS_EN
  logic       lw_valid;
  logic [4:0] lw_addr;
  logic [7:0] lw_data;

  // Both sources must name the last written register; partial matches read normally.
  assign bypass_hit  = lw_valid && (cmd_rs == lw_addr) && (cmd_rt == lw_addr);
  assign bypass_data = lw_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lw_valid <= 1'b0;
      lw_addr  <= 5'd0;
      lw_data  <= 8'd0;
    end else if (error_nx) begin
      lw_valid <= 1'b0;
    end else if (state == WR_WAIT && output_valid) begin
      lw_valid <= 1'b1;
      lw_addr  <= write;
      lw_data  <= write_data;
    end
  end
`else
  assign bypass_hit  = 1'b0;
  assign bypass_data = 8'd0;
`endif

  always_comb begin
    case (op_q)
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      default: alu = a_q & b_q;  // AND; LDI never passes through EXEC
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= 2'd0;
      rd_q        <= 5'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      cnt         <= '0;
      read1       <= 5'd0;
      read2       <= 5'd0;
      write       <= 5'd0;
      write_data  <= 8'd0;
      input_valid <= 3'b000;
      result      <= 8'd0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      op_q        <= op_nx;
      rd_q        <= rd_nx;
      a_q         <= a_nx;
      b_q         <= b_nx;
      cnt         <= cnt_nx;
      read1       <= read1_nx;
      read2       <= read2_nx;
      write       <= write_nx;
      write_data  <= wd_nx;
      input_valid <= iv_nx;
      result      <= result_nx;
      done        <= done_nx;
      error       <= error_nx;
    end
  end

  // Register-file outputs are computed for the state being entered, so they
  // are already stable on the first cycle of every ISSUE/WAIT state.
  always_comb begin
    state_nx  = state;
    op_nx     = op_q;
    rd_nx     = rd_q;
    a_nx      = a_q;
    b_nx      = b_q;
    cnt_nx    = cnt;
    read1_nx  = read1;
    read2_nx  = read2;
    write_nx  = write;
    wd_nx     = write_data;
    iv_nx     = input_valid;
    result_nx = result;
    done_nx   = 1'b0;
    error_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_nx = cmd_op;
          rd_nx = cmd_rd;
          if (cmd_op == OP_LDI) begin
            write_nx = cmd_rd;
            wd_nx    = cmd_imm;
            iv_nx    = 3'b001;
            state_nx = WR_ISSUE;
          end else if (bypass_hit) begin
            a_nx     = bypass_data;
            b_nx     = bypass_data;
            state_nx = EXEC;
          end else begin
            read1_nx = cmd_rs;
            read2_nx = cmd_rt;
            iv_nx    = 3'b110;
            state_nx = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        cnt_nx   = '0;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (output_valid) begin
          a_nx     = out1;
          b_nx     = out2;
          iv_nx    = 3'b000;
          state_nx = EXEC;
        end else if (cnt == TO_LAST) begin
          iv_nx    = 3'b000;
          done_nx  = 1'b1;
          error_nx = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      EXEC: begin
        write_nx = rd_q;
        wd_nx    = alu;
        iv_nx    = 3'b001;
        state_nx = WR_ISSUE;
      end
      WR_ISSUE: begin
        cnt_nx   = '0;
        state_nx = WR_WAIT;
      end
      WR_WAIT: begin
        if (output_valid) begin
          iv_nx     = 3'b000;
          done_nx   = 1'b1;
          result_nx = write_data;
          state_nx  = DONE;
        end else if (cnt == TO_LAST) begin
          // Aborted write: result keeps the previous command's value.
          iv_nx    = 3'b000;
          done_nx  = 1'b1;
          error_nx = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_initiator.sv
// tb_reg_file_initiator: bench for reg_file_initiator with a behavioural register file
// (configurable response delay / stall) and a command-level reference model.
module tb_reg_file_initiator;
  localparam int TIMEOUT = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_OP = 2'b10, LDI = 2'b11;
`ifdef LAST_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_rs, cmd_rt, cmd_rd;
  logic [7:0] cmd_imm;
  logic [4:0] read1, read2, write;
  logic [7:0] write_data, out1, out2, result;
  logic [2:0] input_valid;
  logic       output_valid, done, error;

  always #5 clk = ~clk;

  reg_file_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .read1(read1), .read2(read2), .write(write), .write_data(write_data),
    .input_valid(input_valid), .out1(out1), .out2(out2), .output_valid(output_valid),
    .done(done), .result(result), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Register file: acts once a strobe pattern has been held rf_delay edges.
  logic [7:0] mem [32];
  logic [2:0] prev_iv  = 3'b000;
  int         hold_cnt = 0;
  int         rf_delay = 0;
  bit         rf_stall = 1'b0;
  bit         seed_req = 1'b1;

  always @(posedge clk) begin : rf_model
    int h;
    h = (input_valid == prev_iv) ? hold_cnt + 1 : 0;
    hold_cnt <= h;
    prev_iv  <= input_valid;
    if (seed_req) for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 29 + 3);
    if (input_valid == 3'b000 || rf_stall || h < rf_delay) begin
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b1;
      if (input_valid[2]) out1 <= mem[read1];
      if (input_valid[1]) out2 <= mem[read2];
      if (input_valid[0]) mem[write] <= write_data;
    end
  end

  // Reference model state
  logic [7:0] ref_mem [32];
  bit         lw_ok;
  logic [4:0] lw_addr;
  logic [7:0] last_res;

  typedef struct { int lat; int rd_cyc; int wr_cyc; int bad_io; logic err; logic [7:0] res; } obs_t;
  typedef struct { int lat; int rd_cyc; int wr_cyc; logic err; logic [7:0] res; } exp_t;

  // Drives one command (called at a negedge), observes it to done, updates the model.
  task automatic exec_cmd(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [7:0] imm, output obs_t o, output exp_t e);
    logic [7:0] v;
    bit byp;
    int d, guard;
    case (op)
      ADD:     v = ref_mem[rs] + ref_mem[rt];
      SUB:     v = ref_mem[rs] - ref_mem[rt];
      AND_OP:  v = ref_mem[rs] & ref_mem[rt];
      default: v = imm;
    endcase
    byp = BYP && op != LDI && lw_ok && rs == lw_addr && rt == lw_addr;
    d = rf_delay;
    if (rf_stall) begin
      e.err = 1'b1; e.res = last_res; e.lat = TIMEOUT + 2 + (byp ? 1 : 0);
      e.rd_cyc = (op == LDI || byp) ? 0 : TIMEOUT + 1;
      e.wr_cyc = (op == LDI || byp) ? TIMEOUT + 1 : 0;
    end else begin
      e.err = 1'b0; e.res = v;
      e.lat = (op == LDI) ? 3 + d : (byp ? 4 + d : 6 + 2 * d);
      e.rd_cyc = (op == LDI || byp) ? 0 : 2 + d;
      e.wr_cyc = 2 + d;
    end
    o.lat = -1; o.rd_cyc = 0; o.wr_cyc = 0; o.bad_io = 0; o.err = 1'b0; o.res = 8'h00;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (input_valid === 3'b110) begin
        o.rd_cyc++;
        if (read1 !== rs || read2 !== rt) o.bad_io++;
      end
      if (input_valid === 3'b001) begin
        o.wr_cyc++;
        if (write !== rd || write_data !== v) o.bad_io++;
      end
      if (cmd_ready === 1'b1) o.bad_io++;
      if (error === 1'b1 && done !== 1'b1) o.bad_io++;
      if (done === 1'b1) begin
        o.lat = k; o.err = error; o.res = result;
        if (input_valid !== 3'b000) o.bad_io++;
        break;
      end
    end
    if (!rf_stall) begin
      ref_mem[rd] = v; lw_ok = 1'b1; lw_addr = rd; last_res = v;
    end else begin
      lw_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    repeat (2) @(negedge clk);
    seed_req = 1'b0;
    outs = {read1, read2, write, write_data, result, input_valid, done, error};
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (outs !== 36'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ldi();
    obs_t o; exp_t e;
    exec_cmd(LDI, 5'd0, 5'd0, 5'd3, 8'h2A, o, e);
    n_cmp++; if (o.res !== 8'h2A) begin n_bad++; $display("FAIL ldi_r3_result: got %h want 2a", o.res); end
    n_cmp++; if (o.lat !== 3) begin n_bad++; $display("FAIL ldi_r3_latency: got %0d want 3", o.lat); end
    n_cmp++; if (o.wr_cyc !== 2 || o.bad_io !== 0) begin n_bad++; $display("FAIL ldi_r3_strobes: wr_cyc %0d bad %0d want 2/0", o.wr_cyc, o.bad_io); end
    exec_cmd(LDI, 5'd0, 5'd0, 5'd4, 8'hF0, o, e);
    n_cmp++; if (o.res !== 8'hF0) begin n_bad++; $display("FAIL ldi_r4_result: got %h want f0", o.res); end
    n_cmp++; if (o.lat !== 3) begin n_bad++; $display("FAIL ldi_r4_latency: got %0d want 3", o.lat); end
    n_cmp++; if (mem[4] !== 8'hF0) begin n_bad++; $display("FAIL ldi_r4_mem: got %h want f0", mem[4]); end
  endtask

  task automatic test_alu();
    obs_t o; exp_t e;
    exec_cmd(ADD, 5'd3, 5'd4, 5'd5, 8'h00, o, e);
    n_cmp++; if (o.res !== 8'h1A) begin n_bad++; $display("FAIL add_wrap_result: got %h want 1a", o.res); end
    n_cmp++; if (o.lat !== 6) begin n_bad++; $display("FAIL add_latency: got %0d want 6", o.lat); end
    n_cmp++; if (o.rd_cyc !== 2 || o.bad_io !== 0) begin n_bad++; $display("FAIL add_read_phase: rd_cyc %0d bad %0d want 2/0", o.rd_cyc, o.bad_io); end
    n_cmp++; if (mem[5] !== 8'h1A) begin n_bad++; $display("FAIL add_mem_r5: got %h want 1a", mem[5]); end
    exec_cmd(SUB, 5'd3, 5'd4, 5'd3, 8'h00, o, e);
    n_cmp++; if (o.res !== 8'h3A) begin n_bad++; $display("FAIL sub_rd_eq_rs_result: got %h want 3a", o.res); end
    n_cmp++; if (mem[3] !== 8'h3A) begin n_bad++; $display("FAIL sub_mem_r3: got %h want 3a", mem[3]); end
    exec_cmd(AND_OP, 5'd3, 5'd3, 5'd6, 8'h00, o, e);
    n_cmp++; if (o.res !== 8'h3A) begin n_bad++; $display("FAIL and_rs_eq_rt_result: got %h want 3a", o.res); end
    n_cmp++; if (o.lat !== e.lat || o.rd_cyc !== e.rd_cyc) begin n_bad++; $display("FAIL and_timing: lat %0d rd %0d want %0d/%0d", o.lat, o.rd_cyc, e.lat, e.rd_cyc); end
  endtask

  task automatic test_bypass();
    obs_t o; exp_t e;
    exec_cmd(LDI, 5'd0, 5'd0, 5'd7, 8'h05, o, e);
    exec_cmd(ADD, 5'd7, 5'd7, 5'd8, 8'h00, o, e);
    n_cmp++; if (o.res !== 8'h0A) begin n_bad++; $display("FAIL bypass_add_result: got %h want 0a", o.res); end
    n_cmp++; if (o.lat !== (BYP ? 4 : 6)) begin n_bad++; $display("FAIL bypass_add_latency: got %0d want %0d", o.lat, BYP ? 4 : 6); end
    n_cmp++; if (o.rd_cyc !== (BYP ? 0 : 2)) begin n_bad++; $display("FAIL bypass_read_strobe: got %0d cycles want %0d", o.rd_cyc, BYP ? 0 : 2); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    logic [7:0] keep;
    keep = mem[9];
    rf_stall = 1'b1;
    exec_cmd(ADD, 5'd1, 5'd2, 5'd9, 8'h00, o, e);
    n_cmp++; if (o.err !== 1'b1) begin n_bad++; $display("FAIL timeout_error: got %b want 1", o.err); end
    n_cmp++; if (o.lat !== TIMEOUT + 2) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", o.lat, TIMEOUT + 2); end
    n_cmp++; if (o.wr_cyc !== 0 || o.res !== e.res) begin n_bad++; $display("FAIL timeout_no_write: wr_cyc %0d res %h want 0/%h", o.wr_cyc, o.res, e.res); end
    n_cmp++; if (mem[9] !== keep) begin n_bad++; $display("FAIL timeout_mem: got %h want %h", mem[9], keep); end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL timeout_recover: ready %b error %b want 1/0", cmd_ready, error); end
    rf_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    logic [35:0] outs;
    int guard;
    rf_stall = 1'b1;
    cmd_op = ADD; cmd_rs = 5'd3; cmd_rt = 5'd4; cmd_rd = 5'd12; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (input_valid !== 3'b110) begin n_bad++; $display("FAIL midreset_pre_strobe: got %b want 110", input_valid); end
    rst_n = 1'b0;
    #1;
    outs = {read1, read2, write, write_data, result, input_valid, done, error};
    n_cmp++; if (outs !== 36'd0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_outputs: got %h ready %b want 0/1", outs, cmd_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rf_stall = 1'b0; lw_ok = 1'b0; last_res = 8'h00;
    exec_cmd(LDI, 5'd0, 5'd0, 5'd1, 8'h07, o, e);
    n_cmp++; if (o.res !== 8'h07 || o.err !== 1'b0) begin n_bad++; $display("FAIL midreset_ldi: res %h err %b want 07/0", o.res, o.err); end
    n_cmp++; if (o.lat !== 3 || mem[1] !== 8'h07) begin n_bad++; $display("FAIL midreset_ldi_timing: lat %0d mem %h want 3/07", o.lat, mem[1]); end
  endtask

  task automatic test_back_to_back();
    int guard;
    logic [7:0] r;
    cmd_op = LDI; cmd_rd = 5'd10; cmd_imm = 8'h11; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    cmd_rd = 5'd11; cmd_imm = 8'h22;
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++; if (result !== 8'h11) begin n_bad++; $display("FAIL b2b_first_result: got %h want 11", result); end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    n_cmp++; if (input_valid !== 3'b001 || write !== 5'd11 || cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second_accept: iv %b write %0d ready %b want 001/11/0", input_valid, write, cmd_ready); end
    cmd_valid = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    r = result;
    n_cmp++; if (r !== 8'h22 || mem[10] !== 8'h11 || mem[11] !== 8'h22) begin
      n_bad++; $display("FAIL b2b_second_result: res %h r10 %h r11 %h want 22/11/22", r, mem[10], mem[11]); end
    ref_mem[10] = 8'h11; ref_mem[11] = 8'h22; lw_ok = 1'b1; lw_addr = 5'd11; last_res = 8'h22;
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [1:0] op;
    logic [4:0] rs, rt, rd;
    for (int n = 0; n < 30; n++) begin
      rf_delay = $urandom_range(0, 3);
      op = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 7));
      rt = ($urandom_range(0, 2) == 0) ? rs : 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      exec_cmd(op, rs, rt, rd, 8'($urandom), o, e);
      n_cmp++; if (o.res !== e.res || o.err !== e.err) begin n_bad++; $display("FAIL rand%0d_result: op %0d res %h err %b want %h/%b", n, op, o.res, o.err, e.res, e.err); end
      n_cmp++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL rand%0d_latency: op %0d delay %0d got %0d want %0d", n, op, rf_delay, o.lat, e.lat); end
      n_cmp++; if (o.rd_cyc !== e.rd_cyc || o.wr_cyc !== e.wr_cyc || o.bad_io !== 0) begin
        n_bad++; $display("FAIL rand%0d_strobes: rd %0d wr %0d bad %0d want %0d/%0d/0", n, o.rd_cyc, o.wr_cyc, o.bad_io, e.rd_cyc, e.wr_cyc); end
      n_cmp++; if (mem[rd] !== ref_mem[rd]) begin n_bad++; $display("FAIL rand%0d_mem: r%0d got %h want %h", n, rd, mem[rd], ref_mem[rd]); end
    end
    rf_delay = 0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_rd = 5'd0; cmd_imm = 8'h00;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 29 + 3);
    lw_ok = 1'b0; lw_addr = 5'd0; last_res = 8'h00;
    test_reset();
    test_ldi();
    test_alu();
    test_bypass();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
